// File: rtl/prio_code_decoder.sv
// Priority-code to one-hot grant regenerator. Each grant is held for HOLD_CYCLES cycles,
// and a one-entry pending slot lets the next grant follow with no idle gap.
module prio_code_decoder #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [3:0] grant,
    output logic       grant_active,
    output logic       done_tick,
    output logic       err_tick
);

    localparam int unsigned CODE_W  = 3;
    localparam int unsigned GRANT_W = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GRANT_W-1:0] grant_nxt;
    logic [GRANT_W-1:0] pend_grant, pend_grant_nxt;
    logic               pend_vld, pend_vld_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic               accept;
    logic               code_legal;
    logic               code_illegal;
    logic [GRANT_W-1:0] code_dec;

    function automatic logic [GRANT_W-1:0] decode(input logic [CODE_W-1:0] c);
        logic [GRANT_W-1:0] g;
        case (c)
            3'd1:    g = 4'b0001;
            3'd2:    g = 4'b0010;
            3'd3:    g = 4'b0100;
            3'd4:    g = 4'b1000;
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

    // A code is only accepted while the pending slot is empty.
    assign accept       = code_valid && !pend_vld;
    assign code_legal   = (code_in != 3'd0) && (code_in <= 3'd4);
    assign code_illegal = (code_in > 3'd4);
    assign code_dec     = decode(code_in);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        grant_nxt      = grant;
        pend_vld_nxt   = pend_vld;
        pend_grant_nxt = pend_grant;
        err_nxt        = accept && code_illegal;

        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                if (accept && code_legal) begin
                    grant_nxt = code_dec;
                    cnt_nxt   = CNT_RELOAD;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt == '0) begin
                    // Expiry: pending grant wins, else a same-edge legal code, else idle.
                    if (pend_vld) begin
                        grant_nxt    = pend_grant;
                        cnt_nxt      = CNT_RELOAD;
                        pend_vld_nxt = 1'b0;
                    end else if (accept && code_legal) begin
                        grant_nxt = code_dec;
                        cnt_nxt   = CNT_RELOAD;
                    end else begin
                        grant_nxt = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (accept && code_legal) begin
                        pend_vld_nxt   = 1'b1;
                        pend_grant_nxt = code_dec;
                    end
                end
            end
            default: begin
                grant_nxt = '0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        done_nxt = (state_nxt == ST_ACTIVE) && (cnt_nxt == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            grant        <= '0;
            grant_active <= 1'b0;
            done_tick    <= 1'b0;
            err_tick     <= 1'b0;
            pend_vld     <= 1'b0;
            pend_grant   <= '0;
            code_ready   <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            grant        <= grant_nxt;
            grant_active <= (grant_nxt != '0);
            done_tick    <= done_nxt;
            err_tick     <= err_nxt;
            pend_vld     <= pend_vld_nxt;
            pend_grant   <= pend_grant_nxt;
            code_ready   <= !pend_vld_nxt;
        end
    end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Scoreboard bench for prio_code_decoder: HOLD_CYCLES=4 instance for most scenarios,
// HOLD_CYCLES=1 instance for the single-cycle streaming case.
module tb_prio_code_decoder;

    typedef struct packed {
        logic [3:0] grant;
        logic       act;
        logic       done;
        logic       err;
        logic       rdy;
    } out_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] code, code1;
    logic       valid, valid1;
    logic       rdy, rdy1;
    logic [3:0] grant, grant1;
    logic       act, act1;
    logic       done, done1;
    logic       err, err1;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    prio_code_decoder #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .code_in(code), .code_valid(valid),
        .code_ready(rdy), .grant(grant), .grant_active(act),
        .done_tick(done), .err_tick(err)
    );

    prio_code_decoder #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .code_in(code1), .code_valid(valid1),
        .code_ready(rdy1), .grant(grant1), .grant_active(act1),
        .done_tick(done1), .err_tick(err1)
    );

    function automatic out_t mk(logic [3:0] g, logic d, logic e, logic r);
        out_t o;
        o.grant = g;
        o.act   = (g != 4'b0000);
        o.done  = d;
        o.err   = e;
        o.rdy   = r;
        return o;
    endfunction

    function automatic out_t obs();
        out_t o;
        o.grant = grant; o.act = act; o.done = done; o.err = err; o.rdy = rdy;
        return o;
    endfunction

    function automatic out_t obs1();
        out_t o;
        o.grant = grant1; o.act = act1; o.done = done1; o.err = err1; o.rdy = rdy1;
        return o;
    endfunction

    task automatic test_reset();
        out_t e;
        out_t got;
        reset_n = 1'b0; valid = 1'b0; valid1 = 1'b0; code = '0; code1 = '0;
        repeat (2) @(negedge clk);
        e = mk(4'b0000, 1'b0, 1'b0, 1'b1);
        got = obs();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", got, e); end
        reset_n = 1'b1;
        @(negedge clk);
        got = obs();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", got, e); end
        got = obs1();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_release_h1: got %b expected %b", got, e); end
    endtask

    task automatic test_single();
        logic       v  [8];
        logic [2:0] cd [8];
        out_t       ex [8];
        out_t       got, e;
        for (int i = 0; i < 8; i++) begin v[i] = 1'b0; cd[i] = '0; ex[i] = mk(4'b0000, 1'b0, 1'b0, 1'b1); end
        v[0] = 1'b1; cd[0] = 3'b011;
        for (int i = 0; i < 4; i++) ex[i] = mk(4'b0100, (i == 3), 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            code = cd[c]; valid = v[c];
            exp_q.push_back(ex[c]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL single c%0d: got %b expected %b", c + 1, got, e); end
        end
        valid = 1'b0;
    endtask

    task automatic test_idle_codes();
        logic       v  [5];
        logic [2:0] cd [5];
        out_t       ex [5];
        out_t       got, e;
        for (int i = 0; i < 5; i++) begin v[i] = 1'b0; cd[i] = '0; ex[i] = mk(4'b0000, 1'b0, 1'b0, 1'b1); end
        v[0] = 1'b1; cd[0] = 3'b000;
        v[1] = 1'b1; cd[1] = 3'b110;
        ex[1] = mk(4'b0000, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            code = cd[c]; valid = v[c];
            exp_q.push_back(ex[c]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL idle_codes c%0d: got %b expected %b", c + 1, got, e); end
        end
        valid = 1'b0;
    endtask

    task automatic test_pending();
        logic       v  [11];
        logic [2:0] cd [11];
        out_t       ex [11];
        out_t       got, e;
        for (int i = 0; i < 11; i++) begin v[i] = 1'b0; cd[i] = '0; ex[i] = mk(4'b0000, 1'b0, 1'b0, 1'b1); end
        v[0] = 1'b1; cd[0] = 3'b001;
        v[2] = 1'b1; cd[2] = 3'b100;
        ex[0] = mk(4'b0001, 1'b0, 1'b0, 1'b1);
        ex[1] = mk(4'b0001, 1'b0, 1'b0, 1'b1);
        ex[2] = mk(4'b0001, 1'b0, 1'b0, 1'b0);
        ex[3] = mk(4'b0001, 1'b1, 1'b0, 1'b0);
        ex[4] = mk(4'b1000, 1'b0, 1'b0, 1'b1);
        ex[5] = mk(4'b1000, 1'b0, 1'b0, 1'b1);
        ex[6] = mk(4'b1000, 1'b0, 1'b0, 1'b1);
        ex[7] = mk(4'b1000, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 11; c++) begin
            code = cd[c]; valid = v[c];
            exp_q.push_back(ex[c]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL pending c%0d: got %b expected %b", c + 1, got, e); end
        end
        valid = 1'b0;
    endtask

    // Illegal and null codes during a grant, then a legal code on the expiry edge.
    task automatic test_active_codes();
        logic       v  [10];
        logic [2:0] cd [10];
        out_t       ex [10];
        out_t       got, e;
        for (int i = 0; i < 10; i++) begin v[i] = 1'b0; cd[i] = '0; ex[i] = mk(4'b0000, 1'b0, 1'b0, 1'b1); end
        v[0] = 1'b1; cd[0] = 3'b001;
        v[1] = 1'b1; cd[1] = 3'b111;
        v[2] = 1'b1; cd[2] = 3'b000;
        v[4] = 1'b1; cd[4] = 3'b010;
        ex[0] = mk(4'b0001, 1'b0, 1'b0, 1'b1);
        ex[1] = mk(4'b0001, 1'b0, 1'b1, 1'b1);
        ex[2] = mk(4'b0001, 1'b0, 1'b0, 1'b1);
        ex[3] = mk(4'b0001, 1'b1, 1'b0, 1'b1);
        ex[4] = mk(4'b0010, 1'b0, 1'b0, 1'b1);
        ex[5] = mk(4'b0010, 1'b0, 1'b0, 1'b1);
        ex[6] = mk(4'b0010, 1'b0, 1'b0, 1'b1);
        ex[7] = mk(4'b0010, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            code = cd[c]; valid = v[c];
            exp_q.push_back(ex[c]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL active_codes c%0d: got %b expected %b", c + 1, got, e); end
        end
        valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_t got, e;
        int   n;
        for (int c = 0; c < 18; c++) begin
            n = c + 1;
            code  = 3'b010;
            valid = (c < 12);
            exp_q.push_back(mk((n <= 16) ? 4'b0010 : 4'b0000,
                               (n <= 16) && (n % 4 == 0), 1'b0,
                               (n % 4 == 1) || (n >= 13)));
            @(negedge clk);
            got = obs(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL back_to_back c%0d: got %b expected %b", n, got, e); end
        end
        valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_t got, e;
        code = 3'b001; valid = 1'b1;
        @(negedge clk);
        code = 3'b100; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        e = mk(4'b0001, 1'b0, 1'b0, 1'b0);
        got = obs();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_mid_pre: got %b expected %b", got, e); end
        #2 reset_n = 1'b0;
        #1;
        e = mk(4'b0000, 1'b0, 1'b0, 1'b1);
        got = obs();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_mid_async: got %b expected %b", got, e); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1));
            @(negedge clk);
            got = obs(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL reset_mid_after c%0d: got %b expected %b", c + 1, got, e); end
        end
    endtask

    task automatic test_hold1();
        logic [2:0] seq [4];
        out_t       got, e;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b011; seq[3] = 3'b100;
        for (int c = 0; c < 6; c++) begin
            valid1 = (c < 4);
            code1  = (c < 4) ? seq[c] : 3'b000;
            exp_q.push_back((c < 4) ? mk(4'(1 << c), 1'b1, 1'b0, 1'b1)
                                    : mk(4'b0000, 1'b0, 1'b0, 1'b1));
            @(negedge clk);
            got = obs1(); e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL hold1 c%0d: got %b expected %b", c + 1, got, e); end
        end
        valid1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_idle_codes();
        test_pending();
        test_active_codes();
        test_back_to_back();
        test_reset_mid();
        test_hold1();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_code_decoder.md
Name: prio_code_decoder

Overview:
Receives 3-bit priority codes (000 none, 001..100 = request line 1..4) over a valid/ready stream and regenerates the matching one-hot grant on a 4-bit bus indexed [4:1]. Each grant is held for a programmable number of cycles. A one-entry pending buffer lets back-to-back grants run with no idle gap. It sits on the consumer side of the request priority-encoding path and drives per-line service/enable strobes.

Parameters:
HOLD_CYCLES, 4, number of cycles each grant is held asserted (legal 1..255)
CNT_W, 8, width of the hold counter (must satisfy HOLD_CYCLES <= 2**CNT_W-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
code_in  input  3  priority code: 000 none, 001..100 line 1..4, 101..111 illegal
code_valid  input  1  code_in valid this cycle
code_ready  output  1  block can accept a code this cycle
grant  output  4  one-hot grant, bit index 4:1, registered
grant_active  output  1  high while grant is nonzero
done_tick  output  1  one-cycle pulse in the final cycle of each grant
err_tick  output  1  one-cycle pulse after an illegal code is accepted

Behaviour:
- Transfer occurs on a rising edge where code_valid && code_ready. code_in is sampled only at that edge.
- code_ready = !pend_vld, which is combinational from a register. It stays high in IDLE and in ACTIVE while the pending slot is empty.
- Decode: 001->0001, 010->0010, 011->0100, 100->1000.
- FSM IDLE:
  - A legal nonzero code accepted at edge k gives grant = decode from cycle k+1 for exactly HOLD_CYCLES cycles. The counter loads HOLD_CYCLES-1 and the FSM moves to ACTIVE.
  - Code 000 accepted: consumed, no grant, no done_tick, stays IDLE.
  - Illegal code accepted: consumed, err_tick high in cycle k+1 only, no grant, stays IDLE.
- FSM ACTIVE:
  - Counter decrements each cycle.
  - When the counter is 0, done_tick=1 that cycle.
  - At the next edge, if pend_vld, the pending grant is loaded: grant switches directly with zero gap, the counter reloads and pend_vld clears. Otherwise grant goes to 0000 and the FSM returns to IDLE.
- Pending slot (ACTIVE only):
  - A legal nonzero code accepted in ACTIVE is stored and pend_vld is set.
  - Code 000 or an illegal code is consumed without filling the slot; illegal codes still pulse err_tick next cycle.
  - If an accept and expiry fall on the same edge: the incoming code goes straight into grant when the slot was empty and the code is legal nonzero. Otherwise the FSM goes to IDLE.
- Holding the same code twice gives two separate grants of HOLD_CYCLES each. done_tick pulses twice; grant stays constant across the boundary.
- HOLD_CYCLES=1: each grant lasts 1 cycle and done_tick coincides with every grant cycle.
- grant_active == (grant != 0), registered. grant is always zero or one-hot.
- Reset (asynchronous, any time including mid-grant):
  - grant=0000, grant_active=0, done_tick=0, err_tick=0.
  - pend_vld=0 (code_ready=1 while reset_n is high), counter=0, FSM=IDLE.
  - Pending content is discarded.
- No combinational path exists from code_in or code_valid to any output.

Test Plan:
- Reset then code 011 valid for 1 cycle, HOLD_CYCLES=4 -> grant=0100 on cycles 1..4 after accept, done_tick on cycle 4 only, then grant=0000 and IDLE.
- In IDLE, send 000 then 110 -> no grant. err_tick pulses once, one cycle after 110 is accepted. code_ready stays 1 throughout.
- Send 001, then 100 two cycles later -> 100 goes to pending and code_ready drops to 0. grant goes 0001 x4, then 1000 x4 with no gap. done_tick pulses twice. code_ready returns to 1 after the switch.
- Hold 010 valid continuously for 12 cycles -> grant=0010 steady. done_tick every 4 cycles. code_ready toggles low/high as the slot fills and drains.
- Assert reset_n=0 asynchronously mid-grant with pending full -> all outputs 0 immediately. After release, pending content does not appear and the FSM is IDLE.
- HOLD_CYCLES=1, stream 001,010,011,100 back-to-back -> grant 0001,0010,0100,1000 on consecutive cycles, done_tick high on all four.
